// File: rtl/rotate_fb_sched.sv
// rotate_fb_sched: triple-buffer bank scheduler for the rotation frame store.
// The writer fills one bank and the reader scans another. A completed frame
// waits in a third "ready" slot until the reader picks it up, so the reader
// never sees a torn frame and the writer never overwrites the displayed bank.
// Optional drop/repeat statistics are enabled with the macro ROT_FB_STATS_EN.
module rotate_fb_sched #(
    parameter int BUFSIZE = 76800,
    parameter int AW      = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_frame_start,
    input  logic          wr_frame_done,
    input  logic          rd_frame_start,
    output logic [1:0]    wr_bank,
    output logic [1:0]    rd_bank,
    output logic [AW-1:0] wr_base,
    output logic [AW-1:0] rd_base,
    output logic          wr_active,
    output logic          rd_valid,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   repeat_cnt
);

    typedef enum logic {IDLE, WRITING} wr_state_t;

    localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
    localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);

    wr_state_t   wr_state;
    logic        ready_valid;
    logic [1:0]  ready_bank;

    logic        publish;
    wr_state_t   wr_state_n;
    logic        ready_valid_n;
    logic [1:0]  ready_bank_n;
    logic [1:0]  rd_bank_n;
    logic [1:0]  wr_bank_n;
    logic        rd_valid_n;

    // Bank index to RAM base address as a constant mux (no multiplier).
    function automatic logic [AW-1:0] base_of(input logic [1:0] bank);
        case (bank)
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = '0;
        endcase
    endfunction

    // Lowest bank that is neither the displayed bank nor the pending ready bank.
    function automatic logic [1:0] free_bank(input logic [1:0] rd_b,
                                             input logic       rdy_en,
                                             input logic [1:0] rdy_b);
        if (rd_b != 2'd0 && !(rdy_en && rdy_b == 2'd0))
            free_bank = 2'd0;
        else if (rd_b != 2'd1 && !(rdy_en && rdy_b == 2'd1))
            free_bank = 2'd1;
        else
            free_bank = 2'd2;
    endfunction

    // Next-state decode: done is handled before start, and a frame completing
    // in the same cycle as a reader request goes straight to the reader.
    always_comb begin
        publish       = (wr_state == WRITING) && wr_frame_done;
        wr_state_n    = wr_state;
        ready_valid_n = ready_valid;
        ready_bank_n  = ready_bank;
        rd_bank_n     = rd_bank;
        rd_valid_n    = rd_valid;
        wr_bank_n     = wr_bank;

        if (publish)
            wr_state_n = wr_frame_start ? WRITING : IDLE;
        else if (wr_frame_start)
            wr_state_n = WRITING;

        if (rd_frame_start) begin
            if (publish) begin
                rd_bank_n     = wr_bank;
                ready_valid_n = 1'b0;
                rd_valid_n    = 1'b1;
            end else if (ready_valid) begin
                rd_bank_n     = ready_bank;
                ready_valid_n = 1'b0;
                rd_valid_n    = 1'b1;
            end
        end else if (publish) begin
            ready_bank_n  = wr_bank;
            ready_valid_n = 1'b1;
        end

        if (publish)
            wr_bank_n = free_bank(rd_bank_n, ready_valid_n, ready_bank_n);
    end

    // Registered scheduler state and outputs; bases move with their bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state    <= IDLE;
            wr_active   <= 1'b0;
            wr_bank     <= 2'd0;
            rd_bank     <= 2'd1;
            wr_base     <= '0;
            rd_base     <= BASE1;
            rd_valid    <= 1'b0;
            ready_valid <= 1'b0;
            ready_bank  <= 2'd2;
        end else begin
            wr_state    <= wr_state_n;
            wr_active   <= (wr_state_n == WRITING);
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            wr_base     <= base_of(wr_bank_n);
            rd_base     <= base_of(rd_bank_n);
            rd_valid    <= rd_valid_n;
            ready_valid <= ready_valid_n;
            ready_bank  <= ready_bank_n;
        end
    end

`ifdef ROT_FB_STATS_EN
    logic drop_evt;
    logic repeat_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign drop_evt   = publish && !rd_frame_start && ready_valid;
    assign repeat_evt = rd_frame_start && !publish && !ready_valid && rd_valid;

    // Saturating drop/repeat counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (drop_evt)
                drop_cnt <= sat_inc(drop_cnt);
            if (repeat_evt)
                repeat_cnt <= sat_inc(repeat_cnt);
        end
    end
`else
    assign drop_cnt   = '0;
    assign repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_rotate_fb_sched.sv
// Directed self-checking bench for rotate_fb_sched (default parameters).
module tb_rotate_fb_sched;

    localparam int BUFSIZE = 76800;
    localparam int AW      = 18;
`ifdef ROT_FB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_frame_start = 1'b0;
    logic          wr_frame_done = 1'b0;
    logic          rd_frame_start = 1'b0;
    logic [1:0]    wr_bank;
    logic [1:0]    rd_bank;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic          wr_active;
    logic          rd_valid;
    logic [15:0]   drop_cnt;
    logic [15:0]   repeat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rotate_fb_sched #(.BUFSIZE(BUFSIZE), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
        .rd_frame_start(rd_frame_start),
        .wr_bank(wr_bank), .rd_bank(rd_bank),
        .wr_base(wr_base), .rd_base(rd_base),
        .wr_active(wr_active), .rd_valid(rd_valid),
        .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // One cycle of pulses; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ws, input logic wd, input logic rs);
        @(negedge clk);
        wr_frame_start = ws;
        wr_frame_done  = wd;
        rd_frame_start = rs;
        @(posedge clk);
        #1;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Bank-exclusion invariant every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("inv_wr_ne_rd", 32'(wr_bank != rd_bank), 32'd1);
            if (dut.ready_valid)
                check("inv_wr_ne_ready", 32'(wr_bank != dut.ready_bank), 32'd1);
        end
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 1);
        check("rst_wr_base", wr_base, 0);
        check("rst_rd_base", rd_base, BUFSIZE);
        check("rst_wr_active", wr_active, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_repeat", repeat_cnt, 0);

        // One frame then a reader pickup
        step(1, 0, 0);
        check("t1_active", wr_active, 1);
        check("t1_bank_kept", wr_bank, 0);
        step(0, 1, 0);
        check("t1_idle", wr_active, 0);
        check("t1_wr_bank", wr_bank, 2);
        check("t1_wr_base", wr_base, 2 * BUFSIZE);
        step(0, 0, 1);
        check("t1_rd_bank", rd_bank, 0);
        check("t1_rd_base", rd_base, 0);
        check("t1_rd_valid", rd_valid, 1);

        // Three frames, no reader: writer alternates 2/0, drops counted
        do_reset();
        step(1, 0, 0); step(0, 1, 0);
        check("t2_f1_wr", wr_bank, 2);
        step(1, 0, 0); step(0, 1, 0);
        check("t2_f2_wr", wr_bank, 0);
        step(1, 0, 0); step(0, 1, 0);
        check("t2_f3_wr", wr_bank, 2);
        check("t2_rd_bank", rd_bank, 1);
        check("t2_drop", drop_cnt, 2 * STATS);

        // Writer at half the reader rate
        do_reset();
        step(1, 0, 0); step(0, 1, 0);
        step(0, 0, 1);
        check("t3_rd_a", rd_bank, 0);
        step(0, 0, 1);
        check("t3_rd_rep1", rd_bank, 0);
        check("t3_repeat1", repeat_cnt, STATS);
        step(1, 0, 0); step(0, 1, 0);
        check("t3_wr", wr_bank, 1);
        step(0, 0, 1);
        check("t3_rd_b", rd_bank, 2);
        check("t3_rd_base_b", rd_base, 2 * BUFSIZE);
        step(0, 0, 1);
        check("t3_repeat2", repeat_cnt, 2 * STATS);
        check("t3_drop", drop_cnt, 0);

        // Done and reader start together while a frame is pending
        do_reset();
        step(1, 0, 0); step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 1);
        check("t4_rd_bank", rd_bank, 2);
        check("t4_wr_bank", wr_bank, 0);
        check("t4_drop", drop_cnt, 0);
        check("t4_rd_valid", rd_valid, 1);

        // Aborted frame: restart keeps the bank, one publish only
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        check("t5_abort_bank", wr_bank, 0);
        check("t5_abort_active", wr_active, 1);
        step(0, 1, 0);
        check("t5_wr_bank", wr_bank, 2);
        step(0, 0, 1);
        check("t5_rd_bank", rd_bank, 0);
        step(0, 0, 1);
        check("t5_rd_still", rd_bank, 0);
        check("t5_repeat", repeat_cnt, STATS);
        check("t5_drop", drop_cnt, 0);

        // Done and start in the same cycle: publish, then new frame begins
        do_reset();
        step(1, 0, 0);
        step(1, 1, 0);
        check("t6_active", wr_active, 1);
        check("t6_wr_bank", wr_bank, 2);
        step(0, 1, 0);
        check("t6_wr_bank2", wr_bank, 0);
        check("t6_wr_base2", wr_base, 0);
        check("t6_drop", drop_cnt, STATS);

        // Asynchronous reset mid-frame with a pending ready frame
        do_reset();
        step(1, 0, 0); step(0, 1, 0);
        step(1, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("t7_wr_bank", wr_bank, 0);
        check("t7_rd_bank", rd_bank, 1);
        check("t7_wr_base", wr_base, 0);
        check("t7_rd_base", rd_base, BUFSIZE);
        check("t7_active", wr_active, 0);
        check("t7_drop", drop_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 1);
        check("t7_rd_after", rd_bank, 1);
        check("t7_rd_valid", rd_valid, 0);
        check("t7_repeat", repeat_cnt, 0);
        step(0, 1, 0);
        check("t7_idle_done", wr_bank, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotate_fb_sched.md
Name: rotate_fb_sched

Overview:
- Triple-buffer bank scheduler for the rotation frame store: one RAM holding three frame banks of BUFSIZE words each.
- Tells the pixel writer which bank to fill and the rotated-scan reader which bank to display.
- Guarantees the reader never displays a partially written frame and the writer never overwrites the bank being displayed.
- Sits beside the rotation RAM and supplies the base addresses that the writer and reader address generators add to their offsets.

Parameters:
- BUFSIZE, 76800, words per frame bank (WIDTH*HEIGHT); 3*BUFSIZE must be <= 2^AW.
- AW, 18, address width of the rotation RAM.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_frame_start  in  1  one-cycle pulse: writer begins a frame (writer vblank end).
- wr_frame_done  in  1  one-cycle pulse: writer has completed all pixels of the frame.
- rd_frame_start  in  1  one-cycle pulse: reader is about to scan a new output frame.
- wr_bank  out  2  bank index the writer fills (0..2).
- rd_bank  out  2  bank index the reader scans (0..2).
- wr_base  out  AW  wr_bank*BUFSIZE.
- rd_base  out  AW  rd_bank*BUFSIZE.
- wr_active  out  1  writer FSM in WRITING.
- rd_valid  out  1  at least one complete frame has been handed to the reader since reset.
- drop_cnt  out  16  frames completed but never displayed (optional feature).
- repeat_cnt  out  16  reader frames that re-showed the previous bank (optional feature).

Behaviour:
- Reset values: wr_bank=0, rd_bank=1, wr_base=0, rd_base=BUFSIZE, wr_active=0, rd_valid=0, drop_cnt=0, repeat_cnt=0; internal ready_valid=0, ready_bank=2.
- All outputs are registered and update on the edge that samples the pulse (visible the cycle after the pulse). wr_base and rd_base always change on the same edge as their bank index.
- Base arithmetic: bank*BUFSIZE in AW bits; implement as a constant mux (0, BUFSIZE, 2*BUFSIZE), with no multiplier.
- Writer FSM has two states, IDLE and WRITING:
  - IDLE + wr_frame_start -> WRITING; the bank does not change.
  - WRITING + wr_frame_start -> WRITING; this aborts the frame and restarts the same bank. Nothing is published.
  - WRITING + wr_frame_done -> IDLE; wr_bank is published as the completed frame.
  - IDLE + wr_frame_done is ignored.
  - wr_frame_start and wr_frame_done in the same cycle: done is processed first, then start. Result: the frame is published, the next bank is selected and the state is WRITING.
- Publish, no simultaneous rd_frame_start:
  - ready_bank <= completed bank; ready_valid <= 1.
  - If ready_valid was already 1, the older ready frame is a drop.
- rd_frame_start:
  - If ready_valid=1 (or a publish occurs the same cycle): rd_bank <= ready bank (the just-completed bank takes priority), ready_valid <= 0, rd_valid <= 1.
  - Otherwise rd_bank is unchanged, which is a repeat. It is counted only when rd_valid=1.
- Next writer bank after a publish: the lowest index in {0,1,2} that is neither next rd_bank nor (next ready_valid ? next ready_bank : none). One such bank always exists.
- Invariant: wr_bank != rd_bank at all times, and wr_bank != ready_bank while ready_valid=1. The bench asserts this every cycle.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronously). No publish occurs.

Optional Feature:
- Macro ROT_FB_STATS_EN.
- Defined:
  - drop_cnt increments when a publish overwrites a pending ready frame (ready_valid=1 and no same-cycle rd_frame_start).
  - repeat_cnt increments on rd_frame_start with rd_valid=1 and no frame available.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter logic is synthesised. The ports remain present.

Test Plan:
- Reset, then one write frame (start, done), then rd_frame_start -> rd_bank=0, rd_base=0, rd_valid=1, wr_bank=2, wr_base=2*BUFSIZE.
- Three write frames with no reader pulse -> each publish swaps the writer between the two banks other than rd_bank=1; drop_cnt=2; wr_bank is never 1.
- Writer at half the reader rate (2 rd_frame_start per write frame) -> rd_bank changes every other read frame; repeat_cnt increments once per write frame; drop_cnt=0.
- wr_frame_done and rd_frame_start in the same cycle with ready_valid=1 -> rd_bank = just-completed bank; no drop counted; wr_bank takes the remaining bank.
- wr_frame_start twice without done, then done -> a single publish occurs; the same bank index is kept throughout the aborted frame.
- Reset pulsed while WRITING with ready_valid=1 -> all outputs return to reset values asynchronously; the following rd_frame_start leaves rd_bank=1 and repeat_cnt=0.
